div_32: RTL

DIV_32 -- requirements
Module: div_32

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 18 +
 rtl/div_32.sv | 124 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing constants for the div_32 divider.
package div_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;
    localparam int DIV_WIDTH = 32;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
    localparam int CNT_W = cnt_w(DIV_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a bit, trial subtract, keep or restore).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             bit_o
);
    logic [WIDTH:0] sh, diff;
    always_comb begin
        sh = {rem_i, msb_i};
        diff = sh - {1'b0, dvs_i};
        bit_o = ~diff[WIDTH];
        rem_o = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    end
endmodule

// File: rtl/div_32.sv
// div_32: multi-cycle restoring divider (IDLE/RUN/FIX/DONE) feeding the HI/LO register pair.
// Define DIV_SIGNED_EN for two's-complement operands; the default build divides unsigned.
module div_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_w(WIDTH);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] dd_mag, dv_mag, step_rem, qout_q, rout_q;
    logic zero_q, zero_d, step_bit, accept, busy_q, done_q, dbz_q;
`ifdef DIV_SIGNED_EN
    logic neg_q, neg_d, rsg_q, rsg_d;
    assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
`else
    assign dd_mag = dividend;
    assign dv_mag = divisor;
`endif
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(rem_q),
        .msb_i(quo_q[WIDTH-1]),
        .dvs_i(dvs_q),
        .rem_o(step_rem),
        .bit_o(step_bit)
    );
    // Zero divisor skips RUN/FIX: the result registers are preloaded with the fixed answer.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        zero_d = zero_q;
`ifdef DIV_SIGNED_EN
        neg_d = neg_q;
        rsg_d = rsg_q;
`endif
        if (accept) begin
            zero_d = divisor == '0;
            dvs_d = dv_mag;
            cnt_d = '0;
            rem_d = zero_d ? dividend : '0;
            quo_d = zero_d ? '1 : dd_mag;
            state_d = zero_d ? S_DONE : S_RUN;
`ifdef DIV_SIGNED_EN
            neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rsg_d = dividend[WIDTH-1];
`endif
        end else if (state_q == S_RUN) begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_bit};
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_RUN;
        end else if (state_q == S_FIX) begin
`ifdef DIV_SIGNED_EN
            quo_d = neg_q ? -quo_q : quo_q;
            rem_d = rsg_q ? -rem_q : rem_q;
`endif
            state_d = S_DONE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q <= 1'b0;
            qout_q <= '0;
            rout_q <= '0;
`ifdef DIV_SIGNED_EN
            neg_q <= 1'b0;
            rsg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            zero_q <= zero_d;
            busy_q <= state_q == S_RUN || state_q == S_FIX;
            done_q <= state_q == S_DONE;
`ifdef DIV_SIGNED_EN
            neg_q <= neg_d;
            rsg_q <= rsg_d;
`endif
            // Publish only from DONE so partial results never reach the outputs.
            if (state_q == S_DONE) begin
                qout_q <= quo_q;
                rout_q <= rem_q;
                dbz_q <= zero_q;
            end else if (accept) begin
                dbz_q <= 1'b0;
            end
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign quotient = qout_q;
    assign remainder = rout_q;
    assign div_by_zero = dbz_q;
endmodule
